pb_repeat: RTL
==============

# pb_repeat

Key-event stage that sits directly downstream of the push-button debouncer. It consumes the debounced level and the one-cycle press and release pulses, and turns them into four outputs:
- a step pulse on press;
- a long-press pulse after a hold threshold;
- auto-repeat step pulses while the button stays held;
- a short-press pulse on early release.

Counter and front-panel logic consume these outputs directly in the same clock domain.

## Interface
- TICK_DIV, default 1000: clocks per time tick; must be ≥1.
- LONG_TICKS, default 500: ticks from press to long-press detection; must be ≥1.
- REPEAT_TICKS, default 100: ticks between auto-repeat steps; must be ≥1.
- CW, default 16: width of the prescaler and tick counters. Every parameter value above must fit in CW bits.
- CLK  in  1  system clock; all logic on posedge.
- RSTn  in  1  reset; asynchronous and active-low.
- PB_state  in  1  debounced level; 1 = pressed.
- PB_down  in  1  one-cycle press pulse.
- PB_up  in  1  one-cycle release pulse.
- STEP  out  1  one-cycle step pulse.
- SHORT  out  1  one-cycle pulse on release before the long threshold.
- LONG  out  1  one-cycle pulse at the long threshold.
- HELD  out  1  level; 1 from the LONG pulse until release.

## Operation
- All outputs are registered.
- While RSTn=0, all outputs are 0, the FSM is IDLE, and the prescaler and tick counters are cleared.
- Prescaler: counts 0..TICK_DIV-1. It emits an internal tick in the cycle it equals TICK_DIV-1, then wraps to 0.
- Tick counter: counts ticks, compared against LONG_TICKS or REPEAT_TICKS.
- FSM states and transitions:
  - IDLE:
    - PB_down=1 → PRESS. STEP asserts the next cycle. Prescaler and tick counter clear.
    - All other inputs are ignored.
  - PRESS:
    - PB_up=1 → IDLE. SHORT asserts the next cycle.
    - Else, if PB_state=0 → IDLE silently (abort, no pulse).
    - Else, when the tick count reaches LONG_TICKS → REPEAT. LONG, STEP and HELD assert the next cycle. Tick counter clears; the prescaler keeps running.
  - REPEAT:
    - PB_up=1 or PB_state=0 → IDLE. HELD drops the next cycle; no SHORT.
    - Else, every REPEAT_TICKS ticks → STEP pulse, and the tick counter clears.
- PB_down outside IDLE is ignored.
- A PB_up in the same cycle as a threshold tick wins: no LONG or STEP is issued for that tick.
- A reset mid-hold returns to IDLE. A still-high PB_state produces no events until the next PB_down.
- Counters saturate nowhere, because the parameter constraints keep compares in range.

## Timing
- Let D=TICK_DIV, L=LONG_TICKS, R=REPEAT_TICKS, and PB_down high in cycle T.
- Press STEP: cycle T+1.
- LONG, STEP and HELD rise: cycle T+1+L·D.
- Auto-repeat STEPs: cycles T+1+L·D+k·R·D, for k≥1.
- If PB_up is high in cycle U:
  - U ≤ T+L·D → SHORT at U+1, no LONG.
  - U > T+L·D → HELD falls at U+1.
- Each pulse output is high for exactly one cycle. At most one STEP is issued per cycle.
- Latency from any input pulse to its response is 1 cycle.

## Test plan
Bench parameters: TICK_DIV=4, LONG_TICKS=3, REPEAT_TICKS=2, so L·D=12 and R·D=8.
- Reset: hold RSTn=0, pulse PB_down, release RSTn → all outputs 0 throughout; no pulses before the next PB_down.
- Short press: PB_down at cycle 10, PB_up at cycle 15 → STEP at 11, SHORT at 16, LONG never asserted, HELD stays 0.
- Long hold: PB_down at 10, PB_up at 40 →
  - STEP at 11;
  - LONG and STEP at 23;
  - STEP at 31 and 39;
  - HELD high cycles 23–40, low at 41;
  - no SHORT.
- Boundary:
  - PB_up at 22 → SHORT at 23, no LONG.
  - Separate run, PB_up at 23 → LONG and STEP at 23, HELD low at 24, no SHORT.
  - PB_up at 23 in a cycle where a tick also occurs → no extra STEP.
- Abort and reset mid-operation:
  - PB_state falls at 16 with no PB_up → no SHORT or LONG afterwards.
  - RSTn low at cycle 30 during REPEAT → HELD=0 immediately (asynchronous). PB_state held 1 after reset → no STEP until a fresh PB_down, whose STEP follows one cycle later.

Source files
------------

// File: rtl/pb_repeat.sv
// rtl/pb_repeat.sv - key-event stage: press step, long-press, auto-repeat and short-press pulses
module pb_repeat #(
   parameter int TICK_DIV     = 1000,
   parameter int LONG_TICKS   = 500,
   parameter int REPEAT_TICKS = 100,
   parameter int CW           = 16
) (
   input  logic CLK,
   input  logic RSTn,
   input  logic PB_state,
   input  logic PB_down,
   input  logic PB_up,
   output logic STEP,
   output logic SHORT,
   output logic LONG,
   output logic HELD
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRESS,
      S_REPEAT
   } state_t;

   localparam logic [CW-1:0] C_DIV_LAST  = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] C_LONG_LAST = CW'(LONG_TICKS - 1);
   localparam logic [CW-1:0] C_REP_LAST  = CW'(REPEAT_TICKS - 1);

   state_t        r_state;
   logic [CW-1:0] r_presc;
   logic [CW-1:0] r_tcnt;

   logic w_tick;
   logic w_long_hit;
   logic w_rep_hit;

   assign w_tick     = (r_presc == C_DIV_LAST);
   assign w_long_hit = w_tick && (r_tcnt == C_LONG_LAST);
   assign w_rep_hit  = w_tick && (r_tcnt == C_REP_LAST);

   // Release and abort are checked before threshold hits so a release on a tick suppresses that tick's events.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state <= S_IDLE;
         r_presc <= '0;
         r_tcnt  <= '0;
         STEP    <= 1'b0;
         SHORT   <= 1'b0;
         LONG    <= 1'b0;
         HELD    <= 1'b0;
      end else begin
         STEP  <= 1'b0;
         SHORT <= 1'b0;
         LONG  <= 1'b0;
         r_presc <= w_tick ? '0 : r_presc + CW'(1);

         case (r_state)
            S_IDLE: begin
               if (PB_down) begin
                  r_state <= S_PRESS;
                  STEP    <= 1'b1;
                  r_presc <= '0;
                  r_tcnt  <= '0;
               end
            end

            S_PRESS: begin
               if (PB_up) begin
                  r_state <= S_IDLE;
                  SHORT   <= 1'b1;
               end else if (!PB_state) begin
                  r_state <= S_IDLE;
               end else if (w_long_hit) begin
                  r_state <= S_REPEAT;
                  LONG    <= 1'b1;
                  STEP    <= 1'b1;
                  HELD    <= 1'b1;
                  r_tcnt  <= '0;
               end else if (w_tick) begin
                  r_tcnt <= r_tcnt + CW'(1);
               end
            end

            S_REPEAT: begin
               if (PB_up || !PB_state) begin
                  r_state <= S_IDLE;
                  HELD    <= 1'b0;
               end else if (w_rep_hit) begin
                  STEP   <= 1'b1;
                  r_tcnt <= '0;
               end else if (w_tick) begin
                  r_tcnt <= r_tcnt + CW'(1);
               end
            end

            default: begin
               r_state <= S_IDLE;
               HELD    <= 1'b0;
            end
         endcase
      end
   end

endmodule
